ec_affine_to_ld_163: RTL and testbench

Converts an affine point (x, y) on sect163r2 (y² + xy = x³ + x² + b over GF(2^163)) into randomized Lopez-Dahab projective coordinates (X, Y, Z) = (x·λ, y·λ², λ) using a caller-supplied nonzero λ. In the same pass it checks that the point lies on the curve. It sits in front of the scalar-multiplication datapath as the ingress converter, the counterpart of the projective-to-affine back end. It time-shares one `gf2m_mult163` multiplier and uses `squerer_163` instances.

---
 rtl/ec_affine_to_ld_163.sv | 142 ++++++++++++++
 tb/tb_ec_affine_to_ld_163.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/ec_affine_to_ld_163.sv
// ec_affine_to_ld_163: affine (x, y) on sect163r2 to randomized Lopez-Dahab (x*l, y*l^2, l)
// with an on-curve check, sharing one pipelined GF(2^163) multiplier.
module squerer_163 (
    input  logic [162:0] a,
    output logic [162:0] s
);
    logic [324:0] w;
    // Squaring spreads bits; the reduction folds by f = z^163 + z^7 + z^6 + z^3 + 1.
    always_comb begin
        w = '0;
        for (int i = 0; i < 163; i++) w[2*i] = a[i];
        for (int i = 324; i >= 163; i--)
            if (w[i]) begin
                w[i] = 1'b0;
                w[i-156] = ~w[i-156];
                w[i-157] = ~w[i-157];
                w[i-160] = ~w[i-160];
                w[i-163] = ~w[i-163];
            end
        s = w[162:0];
    end
endmodule

module gf2m_mult163 #(
    parameter int LAT = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [162:0] a,
    input  logic [162:0] b,
    output logic [162:0] p
);
    logic [162:0] c;
    always_comb begin
        c = '0;
        for (int i = 162; i >= 0; i--) begin
            c = {c[161:0], 1'b0} ^ (c[162] ? 163'hC9 : 163'h0);
            c = b[i] ? c ^ a : c;
        end
    end
    generate
        if (LAT <= 1) begin : g_comb
            assign p = c;
        end else begin : g_pipe
            logic [162:0] pl [LAT-1];
            always_ff @(posedge clk or negedge rst_n)
                if (!rst_n) begin
                    for (int i = 0; i < LAT - 1; i++) pl[i] <= '0;
                end else begin
                    pl[0] <= c;
                    for (int i = 1; i < LAT - 1; i++) pl[i] <= pl[i-1];
                end
            assign p = pl[LAT-2];
        end
    endgenerate
endmodule

module ec_affine_to_ld_163 #(
    parameter int           MULT_LAT = 4,
    parameter logic [162:0] B_COEF   = 163'h20A601907B8C953CA1481EB10512F78744A3205FD
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [162:0] x,
    input  logic [162:0] y,
    input  logic [162:0] lambda,
    output logic [162:0] X,
    output logic [162:0] Y,
    output logic [162:0] Z,
    output logic         on_curve,
    output logic         err_zero_z,
    output logic         busy,
    output logic         done
);
    localparam int CW = $clog2(MULT_LAT + 1);
    typedef enum logic [2:0] {IDLE, PREP, M_XL, M_YL2, M_XY, M_X3, CMP, FIN} state_t;
    state_t st;
    logic [CW-1:0] cnt;
    logic [162:0] xr, yr, lr, x2, y2, l2, t1, t2, op_a, op_b, p, sx, sy, sl;
    logic zl, last, mul_st;
    assign last = cnt == CW'(MULT_LAT - 1);
    assign mul_st = st inside {M_XL, M_YL2, M_XY, M_X3};
    squerer_163 u_sx (.a(xr), .s(sx));
    squerer_163 u_sy (.a(yr), .s(sy));
    squerer_163 u_sl (.a(lr), .s(sl));
    gf2m_mult163 #(.LAT(MULT_LAT)) u_mul (.clk(clk), .rst_n(rst_n), .a(op_a), .b(op_b), .p(p));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st <= IDLE;
            cnt <= '0;
            {xr, yr, lr, x2, y2, l2, t1, t2, op_a, op_b} <= '0;
            {X, Y, Z} <= '0;
            {zl, on_curve, err_zero_z, busy, done} <= '0;
        end else begin
            cnt <= mul_st && !last ? cnt + 1'b1 : '0;
            case (st)
                IDLE: if (start) begin
                    {xr, yr, lr} <= {x, y, lambda};
                    busy <= 1'b1;
                    st <= PREP;
                end
                PREP: begin
                    zl <= lr == '0;
                    {l2, x2, y2} <= {sl, sx, sy};
                    {op_a, op_b} <= {xr, lr};
                    st <= lr == '0 ? CMP : M_XL;
                end
                M_XL: if (last) begin
                    {X, Z} <= {p, lr};
                    {op_a, op_b} <= {yr, l2};
                    st <= M_YL2;
                end
                M_YL2: if (last) begin
                    Y <= p;
                    {op_a, op_b} <= {xr, yr};
                    st <= M_XY;
                end
                M_XY: if (last) begin
                    t1 <= y2 ^ p;
                    {op_a, op_b} <= {x2, xr};
                    st <= M_X3;
                end
                M_X3: if (last) begin
                    t2 <= p ^ x2 ^ B_COEF;
                    st <= CMP;
                end
                CMP: begin
                    on_curve <= !zl && t1 == t2;
                    err_zero_z <= zl;
                    done <= 1'b1;
                    st <= FIN;
                end
                default: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    st <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ec_affine_to_ld_163.sv
// tb_ec_affine_to_ld_163: directed scoreboard bench for the affine-to-LD converter.
module tb_ec_affine_to_ld_163;
    localparam logic [162:0] GX = 163'h3F0EBA16286A2D57EA0991168D4994637E8343E36;
    localparam logic [162:0] GY = 163'h0D51FBC6C71A0094FA2CDD545B11C5C0C797324F1;
    localparam logic [162:0] BC = 163'h20A601907B8C953CA1481EB10512F78744A3205FD;

    typedef struct packed {
        logic [162:0] X, Y, Z;
        logic on, err;
    } exp_t;

    logic clk = 0, rst_n = 0, start = 0;
    logic [162:0] x = '0, y = '0, lambda = '0;
    logic [162:0] X, Y, Z;
    logic on_curve, err_zero_z, busy, done;
    int ncomp = 0, nfail = 0, ndone = 0, cyc = 0, t0 = 0, nd0 = 0;
    exp_t q[$];
    exp_t me, e;
    logic [162:0] rx, ry, rl, cy;
    logic [191:0] r192;

    ec_affine_to_ld_163 dut (
        .clk(clk), .rst_n(rst_n), .start(start), .x(x), .y(y), .lambda(lambda),
        .X(X), .Y(Y), .Z(Z), .on_curve(on_curve), .err_zero_z(err_zero_z),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [162:0] gmul(input logic [162:0] a, input logic [162:0] b);
        logic [325:0] w, f;
        w = '0;
        f = '0;
        f[163] = 1'b1; f[7] = 1'b1; f[6] = 1'b1; f[3] = 1'b1; f[0] = 1'b1;
        for (int i = 0; i < 163; i++) if (b[i]) w ^= {163'b0, a} << i;
        for (int i = 325; i >= 163; i--) if (w[i]) w ^= f << (i - 163);
        return w[162:0];
    endfunction

    function automatic logic [162:0] rnd163();
        logic [191:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return r[162:0];
    endfunction

    task automatic chk(input string tag, input logic [162:0] got, input logic [162:0] exp);
        ncomp++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) if (rst_n && done) begin
        ndone++;
        ncomp++;
        assert (q.size() != 0) else begin
            nfail++;
            $error("FAIL unexpected_done: got done with %0d pending expected >0", q.size());
        end
        if (q.size() != 0) begin
            me = q.pop_front();
            chk("X", X, me.X);
            chk("Y", Y, me.Y);
            chk("Z", Z, me.Z);
            chk("on_curve", {162'b0, on_curve}, {162'b0, me.on});
            chk("err_zero_z", {162'b0, err_zero_z}, {162'b0, me.err});
        end
    end

    task automatic launch(input logic [162:0] ix, input logic [162:0] iy, input logic [162:0] il,
                          input exp_t ex);
        @(negedge clk);
        x = ix; y = iy; lambda = il; start = 1'b1;
        q.push_back(ex);
        @(posedge clk);
        #1 start = 1'b0;
        t0 = cyc;
        x = rnd163(); y = rnd163(); lambda = rnd163();
        chk("busy_rise", {162'b0, busy}, 163'd1);
    endtask

    task automatic wait_done(input string tag, input int lat);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1 n++;
        end
        chk(tag, 163'(cyc - t0), 163'(lat));
        @(posedge clk);
        #1;
        chk("busy_fall", {162'b0, busy}, 163'd0);
        chk("done_fall", {162'b0, done}, 163'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_X", X, 0); chk("rst_Y", Y, 0); chk("rst_Z", Z, 0);
        chk("rst_on", {162'b0, on_curve}, 0); chk("rst_err", {162'b0, err_zero_z}, 0);
        chk("rst_busy", {162'b0, busy}, 0); chk("rst_done", {162'b0, done}, 0);
        @(negedge clk) rst_n = 1'b1;

        e = '{X: GX, Y: GY, Z: 163'd1, on: 1'b1, err: 1'b0};
        launch(GX, GY, 163'd1, e);
        wait_done("lat_gen", 18);

        e = '{X: gmul(GX, 163'd2), Y: gmul(GY, 163'd4), Z: 163'd2, on: 1'b1, err: 1'b0};
        launch(GX, GY, 163'd2, e);
        wait_done("lat_gen_l2", 18);

        cy = GY ^ 163'd1;
        e = '{X: GX, Y: cy, Z: 163'd1, on: 1'b0, err: 1'b0};
        launch(GX, cy, 163'd1, e);
        wait_done("lat_corrupt", 18);

        e = '{X: GX, Y: cy, Z: 163'd1, on: 1'b0, err: 1'b1};
        launch(GX, GY, 163'd0, e);
        wait_done("lat_zero_l", 2);

        rx = rnd163(); ry = rnd163(); rl = rnd163() | 163'd1;
        e.X = gmul(rx, rl); e.Y = gmul(ry, gmul(rl, rl)); e.Z = rl; e.err = 1'b0;
        e.on = (gmul(ry, ry) ^ gmul(rx, ry)) == (gmul(gmul(rx, rx), rx) ^ gmul(rx, rx) ^ BC);
        launch(rx, ry, rl, e);
        wait_done("lat_random", 18);

        nd0 = ndone;
        e = '{X: gmul(GX, 163'd3), Y: gmul(GY, gmul(163'd3, 163'd3)), Z: 163'd3, on: 1'b1, err: 1'b0};
        launch(GX, GY, 163'd3, e);
        repeat (4) @(posedge clk);
        #1 x = rx; y = ry; lambda = 163'd5; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("lat_busy_start", 18);
        repeat (25) @(posedge clk);
        #1 chk("single_done", 163'(ndone - nd0), 163'd1);

        e = '{X: GX, Y: GY, Z: 163'd1, on: 1'b1, err: 1'b0};
        launch(GX, GY, 163'd1, e);
        repeat (7) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_X", X, 0); chk("abort_Y", Y, 0); chk("abort_Z", Z, 0);
        chk("abort_on", {162'b0, on_curve}, 0); chk("abort_err", {162'b0, err_zero_z}, 0);
        chk("abort_busy", {162'b0, busy}, 0); chk("abort_done", {162'b0, done}, 0);
        q.delete();
        nd0 = ndone;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1 chk("abort_no_done", 163'(ndone - nd0), 163'd0);

        launch(GX, GY, 163'd1, e);
        wait_done("lat_after_rst", 18);
        repeat (3) @(posedge clk);
        #1 chk("queue_empty", 163'(q.size()), 163'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end
endmodule
